// File: rtl/fetch_prefetch.sv
// Purpose: instruction fetch front-end; one outstanding req/ack fetch feeding a DEPTH-entry {pc, instr} prefetch FIFO.
// Latency: ack-to-instr_valid 1 cycle (0 cycles from an empty FIFO when FETCH_BYPASS_EN is defined).
// Backpressure: a request is issued only if its response is guaranteed a FIFO slot; instr_ready gates pops.
//
// Ports:
//   i_clk, i_reset          - clock, synchronous active-high reset
//   o_imem_req/o_imem_addr  - registered fetch request, held until i_imem_ack
//   i_imem_ack/i_imem_rdata - memory completion and data (same cycle)
//   i_redirect/i_redirect_pc- flush queue and restart fetch (bit 0 of the pc ignored)
//   o_instr_valid/i_instr_ready/o_instr_out/o_instr_pc - head of queue, valid/ready
//   o_fifo_count            - occupied FIFO entries
// Optional feature macro: FETCH_BYPASS_EN (empty-FIFO ack is presented in the same cycle).
module fetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  output logic                     o_imem_req,
  output logic [15:0]              o_imem_addr,
  input  logic                     i_imem_ack,
  input  logic [15:0]              i_imem_rdata,
  input  logic                     i_redirect,
  input  logic [15:0]              i_redirect_pc,
  output logic                     o_instr_valid,
  input  logic                     i_instr_ready,
  output logic [15:0]              o_instr_out,
  output logic [15:0]              o_instr_pc,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  // S_REQ: request outstanding, response kept. S_DROP: request outstanding,
  // response will be discarded because a redirect arrived while it was in flight.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [15:0]    r_fetch_pc;
  logic [15:0]    r_req_addr;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [15:0]    r_mem_pc    [DEPTH];
  logic [15:0]    r_mem_instr [DEPTH];

  logic           w_ack;
  logic           w_empty;
  logic           w_push_raw;
  logic           w_push;
  logic           w_pop;
  logic           w_take;
  logic           w_issue;
  logic [15:0]    w_issue_addr;
  logic [15:0]    w_redir_pc;
  logic [CW-1:0]  w_count_nxt;

  assign o_imem_req   = (r_state != S_IDLE);
  assign o_imem_addr  = r_req_addr;
  assign o_fifo_count = r_count;

  always_comb begin
    w_state_nxt   = r_state;
    w_redir_pc    = i_redirect_pc & 16'hFFFE;
    // An ack with no request outstanding (e.g. a straggler after reset) is ignored.
    w_ack         = i_imem_ack && (r_state != S_IDLE);
    w_empty       = (r_count == '0);
    w_push_raw    = w_ack && (r_state == S_REQ) && !i_redirect;
    o_instr_valid = 1'b0;
    o_instr_out   = 16'h0000;
    o_instr_pc    = 16'h0000;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_take        = 1'b0;
    w_issue       = 1'b0;
    w_issue_addr  = r_fetch_pc;
    w_count_nxt   = r_count;

`ifdef FETCH_BYPASS_EN
    // Empty FIFO: present the acked data directly; only store it if not consumed now.
    if (!w_empty) begin
      o_instr_valid = 1'b1;
      o_instr_out   = r_mem_instr[r_rd_ptr];
      o_instr_pc    = r_mem_pc[r_rd_ptr];
    end else if (w_push_raw) begin
      o_instr_valid = 1'b1;
      o_instr_out   = i_imem_rdata;
      o_instr_pc    = r_req_addr;
    end
    w_take = o_instr_valid && i_instr_ready;
    w_pop  = w_take && !w_empty;
    w_push = w_push_raw && !(w_empty && i_instr_ready);
`else
    if (!w_empty) begin
      o_instr_valid = 1'b1;
      o_instr_out   = r_mem_instr[r_rd_ptr];
      o_instr_pc    = r_mem_pc[r_rd_ptr];
    end
    w_take = o_instr_valid && i_instr_ready;
    w_pop  = w_take;
    w_push = w_push_raw;
`endif

    // Occupancy after this edge; a same-cycle pop frees a slot for the credit check.
    if (i_redirect) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end

    // The port is free if idle or the outstanding request completes this cycle.
    // Issuing only when a slot remains after this edge guarantees the response
    // can always be pushed, since only pops can happen before it returns.
    w_issue      = ((r_state == S_IDLE) || w_ack) && (w_count_nxt < LP_DEPTH);
    w_issue_addr = i_redirect ? w_redir_pc : r_fetch_pc;

    case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_ack)           w_state_nxt = w_issue ? S_REQ : S_IDLE;
        else if (i_redirect) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (w_ack) w_state_nxt = w_issue ? S_REQ : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_issue) begin
        r_req_addr <= w_issue_addr;
        r_fetch_pc <= w_issue_addr + 16'd2;
      end else if (i_redirect) begin
        r_fetch_pc <= w_redir_pc;
      end
      if (i_redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read when counted as occupied.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_req_addr;
      r_mem_instr[r_wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Purpose: directed self-checking bench for fetch_prefetch (DEPTH=4, RESET_PC=0).
// Latency: inputs driven 1 time unit after the rising edge; outputs checked there too.
// Backpressure: instr_ready and memory ack delay are set per scenario.
module tb_fetch_prefetch;

  logic        i_clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        i_imem_ack;
  logic [15:0] i_imem_rdata;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [15:0] o_instr_out;
  logic [15:0] o_instr_pc;
  logic [2:0]  o_fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_cnt = 0;
  int mem_delay = 0;
  bit mem_auto = 1'b1;

  fetch_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instr_out   (o_instr_out),
    .o_instr_pc    (o_instr_pc),
    .o_fifo_count  (o_fifo_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory contents: each halfword is its address XOR a fixed pattern.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Memory answering each request after mem_delay idle cycles.
  task automatic mem_model();
    if (o_imem_req) begin
      if (mem_cnt == mem_delay) begin
        i_imem_ack   = 1'b1;
        i_imem_rdata = mem_word(o_imem_addr);
        mem_cnt      = 0;
      end else begin
        i_imem_ack = 1'b0;
        mem_cnt++;
      end
    end else begin
      i_imem_ack = 1'b0;
      mem_cnt    = 0;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (mem_auto) mem_model();
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    i_redirect = 1'b0;
    i_imem_ack = 1'b0;
    mem_cnt    = 0;
    tick();
    tick();
  endtask

  initial begin
    bit found;
    i_reset       = 1'b1;
    i_imem_ack    = 1'b0;
    i_imem_rdata  = 16'h0000;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'h0000;
    i_instr_ready = 1'b1;

    // ---- reset state, then zero-wait streaming ----
    mem_auto = 1'b1; mem_delay = 0;
    do_reset();
    chk("rst_req",   16'(o_imem_req), 16'h0);
    chk("rst_addr",  o_imem_addr, 16'h0000);
    chk("rst_valid", 16'(o_instr_valid), 16'h0);
    chk("rst_out",   o_instr_out, 16'h0000);
    chk("rst_pc",    o_instr_pc, 16'h0000);
    chk("rst_count", 16'(o_fifo_count), 16'h0);
    i_reset = 1'b0;
    tick();
    chk("s_req0",   16'(o_imem_req), 16'h1);
    chk("s_addr0",  o_imem_addr, 16'h0000);
    chk("s_valid0", 16'(o_instr_valid), 16'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("s_addr",  o_imem_addr, 16'(2 * k));
      chk("s_valid", 16'(o_instr_valid), 16'h1);
      chk("s_pc",    o_instr_pc, 16'(2 * (k - 1)));
      chk("s_out",   o_instr_out, mem_word(16'(2 * (k - 1))));
      chk("s_count", 16'(o_fifo_count), 16'h1);
    end

    // ---- fill to DEPTH with consumer stalled, then one pop ----
    do_reset();
    i_instr_ready = 1'b0;
    i_reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("full_count", 16'(o_fifo_count), 16'h4);
    chk("full_req",   16'(o_imem_req), 16'h0);
    chk("full_pc",    o_instr_pc, 16'h0000);
    tick();
    chk("full_hold_req",   16'(o_imem_req), 16'h0);
    chk("full_hold_count", 16'(o_fifo_count), 16'h4);
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    chk("pop_count", 16'(o_fifo_count), 16'h3);
    chk("pop_req",   16'(o_imem_req), 16'h1);
    chk("pop_addr",  o_imem_addr, 16'h0008);
    chk("pop_head",  o_instr_pc, 16'h0002);
    tick();
    chk("refill_count", 16'(o_fifo_count), 16'h4);
    chk("refill_req",   16'(o_imem_req), 16'h0);

    // ---- redirect while a slow request is pending ----
    mem_delay = 3;
    do_reset();
    i_instr_ready = 1'b1;
    i_reset = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (o_imem_req && o_imem_addr == 16'h0006) found = 1'b1;
    end
    chk("wait_a6", 16'(found), 16'h1);
    i_redirect = 1'b1; i_redirect_pc = 16'h0040;
    tick();
    i_redirect = 1'b0;
    chk("rd_hold_addr", o_imem_addr, 16'h0006);
    chk("rd_hold_req",  16'(o_imem_req), 16'h1);
    chk("rd_count",     16'(o_fifo_count), 16'h0);
    tick();
    tick();
    chk("rd_ack_cycle", 16'(i_imem_ack), 16'h1);
    chk("rd_ack_addr",  o_imem_addr, 16'h0006);
    tick();
    chk("rd_tgt_addr", o_imem_addr, 16'h0040);
    chk("rd_dropped",  16'(o_instr_valid), 16'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (o_instr_valid) found = 1'b1;
    end
    chk("rd_wait_valid", 16'(found), 16'h1);
    chk("rd_first_pc",   o_instr_pc, 16'h0040);
    chk("rd_first_out",  o_instr_out, mem_word(16'h0040));

    // ---- redirect + ack + pop in one cycle with 2 entries queued ----
    mem_auto = 1'b0;
    do_reset();
    i_instr_ready = 1'b0;
    i_reset = 1'b0;
    tick();
    i_imem_ack = 1'b1; i_imem_rdata = mem_word(16'h0000);
    tick();
    i_imem_rdata = mem_word(16'h0002);
    tick();
    chk("rap_count", 16'(o_fifo_count), 16'h2);
    chk("rap_addr",  o_imem_addr, 16'h0004);
    i_imem_rdata = 16'hDEAD;
    i_instr_ready = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 16'h0100;
    tick();
    i_imem_ack = 1'b0; i_redirect = 1'b0; i_instr_ready = 1'b0;
    chk("rap_count0", 16'(o_fifo_count), 16'h0);
    chk("rap_valid0", 16'(o_instr_valid), 16'h0);
    chk("rap_req",    16'(o_imem_req), 16'h1);
    chk("rap_tgt",    o_imem_addr, 16'h0100);
    i_imem_ack = 1'b1; i_imem_rdata = mem_word(16'h0100);
    tick();
    i_imem_ack = 1'b0;
    chk("rap_pc",    o_instr_pc, 16'h0100);
    chk("rap_out",   o_instr_out, mem_word(16'h0100));
    chk("rap_count", 16'(o_fifo_count), 16'h1);

    // ---- address wrap and odd redirect target ----
    mem_auto = 1'b1; mem_delay = 0;
    do_reset();
    i_instr_ready = 1'b1;
    i_reset = 1'b0;
    tick();
    i_redirect = 1'b1; i_redirect_pc = 16'hFFFE;
    tick();
    i_redirect = 1'b0;
    chk("wrap_addr0", o_imem_addr, 16'hFFFE);
    chk("wrap_valid", 16'(o_instr_valid), 16'h0);
    tick();
    chk("wrap_addr1", o_imem_addr, 16'h0000);
    chk("wrap_pc0",   o_instr_pc, 16'hFFFE);
    chk("wrap_out0",  o_instr_out, mem_word(16'hFFFE));
    tick();
    chk("wrap_addr2", o_imem_addr, 16'h0002);
    chk("wrap_pc1",   o_instr_pc, 16'h0000);
    i_redirect = 1'b1; i_redirect_pc = 16'h0013;
    tick();
    i_redirect = 1'b0;
    chk("odd_addr",  o_imem_addr, 16'h0012);
    chk("odd_valid", 16'(o_instr_valid), 16'h0);
    tick();
    chk("odd_pc", o_instr_pc, 16'h0012);

    // ---- reset mid-transaction with 3 queued, late ack ignored ----
    mem_auto = 1'b0;
    do_reset();
    i_instr_ready = 1'b0;
    i_reset = 1'b0;
    tick();
    i_imem_ack = 1'b1; i_imem_rdata = mem_word(16'h0000);
    tick();
    tick();
    tick();
    i_imem_ack = 1'b0;
    tick();
    chk("mid_count", 16'(o_fifo_count), 16'h3);
    chk("mid_addr",  o_imem_addr, 16'h0006);
    i_reset = 1'b1;
    tick();
    chk("mid_rst_req",   16'(o_imem_req), 16'h0);
    chk("mid_rst_count", 16'(o_fifo_count), 16'h0);
    chk("mid_rst_valid", 16'(o_instr_valid), 16'h0);
    i_reset = 1'b0;
    i_imem_ack = 1'b1; i_imem_rdata = 16'hBEEF;
    tick();
    i_imem_ack = 1'b0;
    chk("late_count", 16'(o_fifo_count), 16'h0);
    chk("late_valid", 16'(o_instr_valid), 16'h0);
    chk("late_req",   16'(o_imem_req), 16'h1);
    chk("late_addr",  o_imem_addr, 16'h0000);
    i_imem_ack = 1'b1; i_imem_rdata = mem_word(16'h0000);
    tick();
    i_imem_ack = 1'b0;
    chk("post_valid", 16'(o_instr_valid), 16'h1);
    chk("post_pc",    o_instr_pc, 16'h0000);
    chk("post_out",   o_instr_out, mem_word(16'h0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Instruction fetch front-end for the 16-bit single-cycle core. It drives a multi-cycle instruction memory over a req/ack handshake and buffers fetched halfwords in a DEPTH-entry prefetch FIFO. It presents them, with their PCs, to the decode/datapath stage over a valid/ready interface. The datapath drives `redirect` on a taken beq, j, jal or jr, which flushes the queue and restarts fetch at the target.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `RESET_PC`, 16'h0000: first fetch address after reset; bit 0 must be 0.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: fetch request; held until `imem_ack`.
- `imem_addr` out 16: byte address of the request; stable while `imem_req`=1.
- `imem_ack` in 1: memory completion; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 16: fetched instruction.
- `redirect` in 1: flush the queue and restart fetch.
- `redirect_pc` in 16: restart address; bit 0 is forced to 0.
- `instr_valid` out 1: head entry available.
- `instr_ready` in 1: consumer accepts the head entry.
- `instr_out` out 16: head instruction; 0 when empty.
- `instr_pc` out 16: address of `instr_out`; 0 when empty.
- `fifo_count` out $clog2(DEPTH)+1: number of occupied entries.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `req_addr`: address of the in-flight request.
  - `busy`: a request is outstanding.
  - `discard`: the in-flight response is to be dropped.
  - FIFO of {pc, instr}.
- At most one request is outstanding.
- Issue condition: `busy`=0 and `fifo_count` < DEPTH.
  - On issue, `imem_req`=1 and `imem_addr`=`req_addr`=`fetch_pc`.
  - `fetch_pc` advances by 2, modulo 2^16: 0xFFFE wraps to 0x0000.
- A credit check guarantees a push never targets a full FIFO: the request is issued only if a slot exists, with the same-cycle pop counted.
- Ack with `discard`=0: push {`req_addr`, `imem_rdata`}.
- Ack with `discard`=1: the data is dropped and `discard` clears.
- Ack while `imem_req`=0 is ignored.
- Pop happens when `instr_valid`=1 and `instr_ready`=1. A simultaneous push and pop leaves `fifo_count` unchanged.
- Redirect has priority over everything:
  - The FIFO empties (`fifo_count`=0 next cycle). A same-cycle pop counts as consumed.
  - `fetch_pc` <= {`redirect_pc`[15:1], 1'b0}.
  - If a request is outstanding and not acked this cycle, `imem_req` and `imem_addr` stay held (handshake is never aborted) and `discard` <= 1.
  - A same-cycle ack's data is dropped.
  - A redirect while `discard`=1 only updates `fetch_pc`.
- Reset overrides redirect. All state clears and `fetch_pc` <= RESET_PC.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `fifo_count`=0.
  - `busy`=0, `discard`=0.
- `imem_req` is registered. It rises in the first cycle after `reset` deasserts.
- Back-to-back issue: if the issue condition holds at the ack edge, the next request is presented in the following cycle. A zero-wait memory (ack every cycle) yields 1 instruction/cycle.
- Ack-to-`instr_valid` latency: 1 cycle (registered FIFO).
- After a redirect:
  - With no request outstanding, the request to the target is presented the next cycle.
  - With a request outstanding, the target request goes out the cycle after the discarded ack.
- Full: `imem_req` stays 0 while `fifo_count`=DEPTH. It reasserts the cycle after the first pop.
- Reset mid-transaction drops the outstanding request; any later ack arrives with `imem_req`=0 and is ignored.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty and an ack arrives with `discard`=0 and no redirect, `instr_valid`=1 and `instr_out`/`instr_pc` = `imem_rdata`/`req_addr` in the same cycle.
  - If `instr_ready`=1, the entry is not pushed. Ack-to-valid latency is 0.
- Undefined: all data passes through the FIFO with 1-cycle latency; outputs are purely registered.

## Test plan
- Reset release, memory acks every requested cycle, `instr_ready`=1 -> `imem_addr` 0x0000, 0x0002, 0x0004… on consecutive cycles; `instr_valid` from cycle 2 with `instr_pc` 0x0000, then +2 per cycle.
- DEPTH=4, `instr_ready`=0 -> exactly 4 acks accepted, `fifo_count`=4, `imem_req` low. One cycle of `instr_ready`=1 -> head 0x0000 popped, next request to 0x0008.
- Ack delay 3 cycles, redirect to 0x0040 while the request to 0x0006 is pending -> `imem_addr` holds 0x0006 until ack, that data is dropped, next request is 0x0040, first delivered `instr_pc`=0x0040.
- Redirect, ack and pop in the same cycle with 2 entries queued -> `fifo_count`=0 next cycle, ack data never appears, next request is to the target.
- Redirect `redirect_pc`=0xFFFE -> fetches 0xFFFE then 0x0000. Redirect `redirect_pc`=0x0013 -> fetch 0x0012.
- Reset asserted with 3 entries queued and a request outstanding -> next cycle `imem_req`=0, `fifo_count`=0, `instr_valid`=0; a late ack is ignored and the first post-reset request is to RESET_PC.
